// File: rtl/mux_scan_pkg.sv
// Shared types and widths for the mux channel scanner.
// Optional MUX_SCAN_CONTINUOUS_EN makes the scanner restart after each accepted frame.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mux_settle_timer.sv
// Settle interval counter: clears on demand, counts while enabled,
// flags the last cycle of the interval.
module mux_settle_timer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_done
);

    localparam logic [CNT_W-1:0] LP_TC = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = i_en && (r_cnt == LP_TC);

endmodule

// File: rtl/mux_channel_scanner.sv
// Steps a 4-to-1 mux through its channels and packs the samples into a frame.
// Define MUX_SCAN_CONTINUOUS_EN to rescan automatically after each accept.
module mux_channel_scanner
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       mux_out,
    output logic       s1,
    output logic       s0,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);

    state_t            r_state;
    state_t            w_next;
    logic [CH_W-1:0]   r_ch;
    logic [NUM_CH-2:0] r_shadow;
    logic [3:0]        r_frame;
    logic              r_fv;
    logic              w_accept;
    logic              w_tdone;
    logic              w_ten;
    logic              w_last;

    assign w_ten    = (r_state == ST_SETTLE);
    assign w_accept = r_fv && frame_ready;
    assign w_last   = (r_ch == CH_W'(NUM_CH - 1));

    mux_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (!w_ten),
        .i_en    (w_ten),
        .o_done  (w_tdone)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start && !abort) w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)        w_next = ST_IDLE;
                else if (w_tdone) w_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)       w_next = ST_IDLE;
                else if (w_last) w_next = ST_DONE;
                else             w_next = ST_SETTLE;
            end
            ST_DONE: begin
`ifdef MUX_SCAN_CONTINUOUS_EN
                if (w_accept) w_next = ST_SETTLE;
`else
                if (w_accept) w_next = ST_IDLE;
`endif
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ch     <= '0;
            r_shadow <= '0;
            r_frame  <= '0;
            r_fv     <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                ST_IDLE: begin
                    r_ch     <= '0;
                    r_shadow <= '0;
                end
                ST_SETTLE: begin
                    if (abort) begin
                        r_ch     <= '0;
                        r_shadow <= '0;
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        r_ch     <= '0;
                        r_shadow <= '0;
                    end else if (w_last) begin
                        r_frame <= {mux_out, r_shadow};
                        r_fv    <= 1'b1;
                    end else begin
                        unique case (r_ch)
                            2'd0:    r_shadow[0] <= mux_out;
                            2'd1:    r_shadow[1] <= mux_out;
                            default: r_shadow[2] <= mux_out;
                        endcase
                        r_ch <= r_ch + 1'b1;
                    end
                end
                ST_DONE: begin
                    // abort is deliberately ignored here: the frame is owed downstream
                    if (w_accept) begin
                        r_fv     <= 1'b0;
                        r_ch     <= '0;
                        r_shadow <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign s1          = busy && r_ch[1];
    assign s0          = busy && r_ch[0];
    assign frame       = r_frame;
    assign frame_valid = r_fv;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Directed bench for mux_channel_scanner with a behavioural 4-to-1 mux.
// Covers reset, scan timing, backpressure, abort, mid-scan reset, continuous mode.
module tb_mux_channel_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       mux_out;
    logic       s1;
    logic       s0;
    logic [3:0] frame;
    logic       frame_valid;
    logic       frame_ready;
    logic       busy;
    logic [3:0] mux_in;
    logic [1:0] sel;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    assign sel     = {s1, s0};
    assign mux_out = mux_in[sel];

    mux_channel_scanner #(
        .SETTLE_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .mux_out     (mux_out),
        .s1          (s1),
        .s0          (s0),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        frame_ready = 1'b0;
        mux_in      = 4'b0000;
        step(2);
        check("rst_sel", 8'(sel), 8'd0);
        check("rst_fv", 8'(frame_valid), 8'd0);
        check("rst_frame", 8'(frame), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_sel", 8'(sel), 8'd0);
        end

`ifdef MUX_SCAN_CONTINUOUS_EN
        frame_ready = 1'b1;
        mux_in      = 4'b1010;
        kick();
        step(12);
        check("c1_fv", 8'(frame_valid), 8'd1);
        check("c1_frame", 8'(frame), 8'hA);
        mux_in = 4'b0110;
        step();
        check("c_gap_fv", 8'(frame_valid), 8'd0);
        check("c_gap_busy", 8'(busy), 8'd1);
        check("c_gap_sel", 8'(sel), 8'd0);
        step(11);
        check("c2_early", 8'(frame_valid), 8'd0);
        step();
        check("c2_fv", 8'(frame_valid), 8'd1);
        check("c2_frame", 8'(frame), 8'h6);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("c_abort_busy", 8'(busy), 8'd0);
`else
        // basic scan: select held 3 cycles per channel
        frame_ready = 1'b1;
        mux_in      = 4'b1010;
        kick();
        check("b_busy", 8'(busy), 8'd1);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            check("b_sel", 8'(sel), 8'(k / 3));
            check("b_fv_low", 8'(frame_valid), 8'd0);
        end
        step();
        check("b_fv", 8'(frame_valid), 8'd1);
        check("b_frame", 8'(frame), 8'hA);
        check("b_sel_done", 8'(sel), 8'd3);
        step();
        check("b_fv_clr", 8'(frame_valid), 8'd0);
        check("b_idle", 8'(busy), 8'd0);
        check("b_hold", 8'(frame), 8'hA);
        check("b_sel_idle", 8'(sel), 8'd0);

        // backpressure
        frame_ready = 1'b0;
        kick();
        step(12);
        check("bp_fv", 8'(frame_valid), 8'd1);
        mux_in = 4'b0101;
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_frame", 8'(frame), 8'hA);
            check("bp_sel", 8'(sel), 8'd3);
            check("bp_fvh", 8'(frame_valid), 8'd1);
        end
        frame_ready = 1'b1;
        step();
        check("bp_rel_fv", 8'(frame_valid), 8'd0);
        check("bp_rel_busy", 8'(busy), 8'd0);

        // start ignored mid-scan, abort in channel 2 settle
        mux_in = 4'b0110;
        kick();
        step(3);
        start = 1'b1;
        step(3);
        start = 1'b0;
        check("ab_sel2", 8'(sel), 8'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_busy", 8'(busy), 8'd0);
        check("ab_sel", 8'(sel), 8'd0);
        check("ab_frame", 8'(frame), 8'hA);
        step(15);
        check("ab_fv", 8'(frame_valid), 8'd0);
        check("ab_stay", 8'(busy), 8'd0);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", 8'(busy), 8'd0);

        // abort in DONE has no effect
        frame_ready = 1'b0;
        kick();
        step(12);
        check("ad_fv", 8'(frame_valid), 8'd1);
        check("ad_frame", 8'(frame), 8'h6);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ad_fv_kept", 8'(frame_valid), 8'd1);
        check("ad_busy", 8'(busy), 8'd1);
        check("ad_sel", 8'(sel), 8'd3);
        frame_ready = 1'b1;
        step();
        check("ad_rel", 8'(frame_valid), 8'd0);

        // reset at E0+7 loses the scan
        mux_in = 4'b1100;
        kick();
        step(6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_busy", 8'(busy), 8'd0);
        check("mr_sel", 8'(sel), 8'd0);
        check("mr_frame", 8'(frame), 8'd0);
        check("mr_fv", 8'(frame_valid), 8'd0);
        step(15);
        check("mr_nofv", 8'(frame_valid), 8'd0);
        kick();
        step(11);
        check("mr_early", 8'(frame_valid), 8'd0);
        step();
        check("mr_fv2", 8'(frame_valid), 8'd1);
        check("mr_frame2", 8'(frame), 8'hC);
        step();
        check("mr_done", 8'(busy), 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
